// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and helpers shared by the sync generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W  = 10;

  localparam int unsigned H_DISP   = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_DISP   = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;

  // Sync pulse windows, start inclusive, end exclusive.
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = H_DISP + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = V_DISP + V_FP + V_SYNC;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned div_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: counts system clocks and strobes once per pixel period.
// tick_c is the combinational strobe the counters use so they load on the
// same edge that raises the registered p_tick.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick,
  output logic tick_c
);

  localparam int unsigned DIV_W = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  assign tick_c = (div == DIV_LAST);

  // Next divider value: wrap after the last clock of a pixel period.
  always_comb begin
    div_next = div + DIV_W'(1);
    if (tick_c) begin
      div_next = '0;
    end
  end

  // Divider and registered pixel strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      div    <= div_next;
      p_tick <= tick_c;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel tick, H/V counters and a registered output stage
// (pixel_x/pixel_y/video_on/hsync/vsync) that lags the counters by one tick.
// Optional macro VGA_SYNC_FRAME_STROBE_EN adds a one-clock frame_start strobe
// on the edge where the outputs load pixel (0,0).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_DISP   = vga_timing_pkg::H_DISP,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_DISP   = vga_timing_pkg::V_DISP,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               p_tick,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y
`ifdef VGA_SYNC_FRAME_STROBE_EN
  ,
  output logic               frame_start
`endif
);

  localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_DISP);
  localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_DISP);
  localparam logic [COORD_W-1:0] HS_BEGIN  = COORD_W'(H_DISP + H_FP);
  localparam logic [COORD_W-1:0] HS_FINISH = COORD_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEGIN  = COORD_W'(V_DISP + V_FP);
  localparam logic [COORD_W-1:0] VS_FINISH = COORD_W'(V_DISP + V_FP + V_SYNC);

  logic               tick_c;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] v_next;
  logic               video_on_c;
  logic               hs_active_c;
  logic               vs_active_c;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick),
    .tick_c  (tick_c)
  );

  // Counter advance: h wraps at end of line, v steps only on h wrap.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (tick_c) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_next = h_cnt + COORD_W'(1);
      end
    end
  end

  // Decode of the current (pre-increment) counter position.
  always_comb begin
    video_on_c  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_active_c = (h_cnt >= HS_BEGIN) && (h_cnt < HS_FINISH);
    vs_active_c = (v_cnt >= VS_BEGIN) && (v_cnt < VS_FINISH);
  end

  // Position counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Output stage: all outputs load together on the pixel tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel_x  <= '0;
      pixel_y  <= '0;
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else if (tick_c) begin
      pixel_x  <= h_cnt;
      pixel_y  <= v_cnt;
      video_on <= video_on_c;
      hsync    <= hs_active_c ? SYNC_POL : ~SYNC_POL;
      vsync    <= vs_active_c ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_SYNC_FRAME_STROBE_EN
  // Frame strobe: one clock, on the edge that loads pixel (0,0).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick_c && (h_cnt == '0) && (v_cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a standard 640x480 instance (CLK_DIV=4) and a
// shrunken-geometry instance (CLK_DIV=1) so wrap and vsync are reached quickly.
// Expected outputs come from a position model: tick n -> (n mod H_TOTAL,
// (n div H_TOTAL) mod V_TOTAL) with sync/visible windows applied.
module tb_vga_sync_gen;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
  } exp_t;

  localparam int unsigned T1_HD = 8, T1_HF = 2, T1_HS = 3, T1_HB = 2;
  localparam int unsigned T1_VD = 6, T1_VF = 1, T1_VS = 2, T1_VB = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       pt0, von0, hs0, vs0, fs0;
  logic [9:0] px0, py0;
  logic       pt1, von1, hs1, vs1, fs1;
  logic [9:0] px1, py1;

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1;
  int unsigned since0 = 0, since1 = 0;
  int unsigned tickn0 = 0, tickn1 = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(.CLK_DIV(4), .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .p_tick(pt0), .video_on(von0),
    .hsync(hs0), .vsync(vs0), .pixel_x(px0), .pixel_y(py0)
`ifdef VGA_SYNC_FRAME_STROBE_EN
    , .frame_start(fs0)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISP(T1_HD), .H_FP(T1_HF), .H_SYNC(T1_HS), .H_BP(T1_HB),
    .V_DISP(T1_VD), .V_FP(T1_VF), .V_SYNC(T1_VS), .V_BP(T1_VB), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .p_tick(pt1), .video_on(von1),
    .hsync(hs1), .vsync(vs1), .pixel_x(px1), .pixel_y(py1)
`ifdef VGA_SYNC_FRAME_STROBE_EN
    , .frame_start(fs1)
`endif
  );

`ifndef VGA_SYNC_FRAME_STROBE_EN
  assign fs0 = 1'b0;
  assign fs1 = 1'b0;
`endif

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = 10'd0; e.y = 10'd0; e.von = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    return e;
  endfunction

  // Reference: position and decode of the n-th pixel tick after reset.
  function automatic exp_t model(input int d, input int unsigned n);
    int unsigned hd, hf, hsw, hb, vd, vf, vsw, vb, ht, vt, x, y;
    exp_t e;
    if (d == 0) begin
      hd = 640; hf = 16; hsw = 96; hb = 48; vd = 480; vf = 10; vsw = 2; vb = 33;
    end else begin
      hd = T1_HD; hf = T1_HF; hsw = T1_HS; hb = T1_HB;
      vd = T1_VD; vf = T1_VF; vsw = T1_VS; vb = T1_VB;
    end
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    x = n % ht;
    y = (n / ht) % vt;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.von = (x < hd) && (y < vd);
    e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
    e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
    return e;
  endfunction

  // Stimulus-side model: at each clock decide whether a tick is due and queue it.
  always @(posedge clk) begin
    if (!reset_n) begin
      since0 = 0; since1 = 0; tickn0 = 0; tickn1 = 0;
      q0.delete(); q1.delete();
      last0 = reset_exp(); last1 = reset_exp();
    end else begin
      since0++;
      since1++;
      if (since0 % 4 == 0) begin q0.push_back(model(0, tickn0)); tickn0++; end
      q1.push_back(model(1, tickn1)); tickn1++;
    end
  end

  task automatic compare(input int d, input string nm, input logic [9:0] x, input logic [9:0] y,
                         input logic von, input logic hs, input logic vs, input exp_t e);
    checks++;
    if (x !== e.x || y !== e.y || von !== e.von || hs !== e.hs || vs !== e.vs) begin
      errors++;
      $display("FAIL dut%0d %s: got x=%0d y=%0d von=%b hs=%b vs=%b, want x=%0d y=%0d von=%b hs=%b vs=%b",
               d, nm, x, y, von, hs, vs, e.x, e.y, e.von, e.hs, e.vs);
    end
  endtask

  // Monitor: pop an expectation whenever a DUT presents a pixel tick.
  task automatic mon(input int d, input logic pt, input logic [9:0] x, input logic [9:0] y,
                     input logic von, input logic hs, input logic vs, input logic fs);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (!pt && !have) begin
      e = (d == 0) ? last0 : last1;
      compare(d, "hold", x, y, von, hs, vs, e);
`ifdef VGA_SYNC_FRAME_STROBE_EN
      if (fs !== 1'b0) begin
        checks++; errors++;
        $display("FAIL dut%0d frame_start off-tick: got %b want 0", d, fs);
      end
`endif
      return;
    end
    if (pt && !have) begin
      checks++; errors++;
      $display("FAIL dut%0d spurious p_tick: got 1 want 0 at x=%0d y=%0d", d, x, y);
      return;
    end
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    if (d == 0) last0 = e; else last1 = e;
    if (!pt) begin
      checks++; errors++;
      $display("FAIL dut%0d missed p_tick: got 0 want 1 (expected x=%0d y=%0d)", d, e.x, e.y);
      return;
    end
    compare(d, "tick", x, y, von, hs, vs, e);
`ifdef VGA_SYNC_FRAME_STROBE_EN
    checks++;
    if (fs !== (e.x == 10'd0 && e.y == 10'd0)) begin
      errors++;
      $display("FAIL dut%0d frame_start: got %b want %b at x=%0d y=%0d",
               d, fs, (e.x == 10'd0 && e.y == 10'd0), e.x, e.y);
    end
`endif
  endtask

  always @(negedge clk) begin
    mon(0, pt0, px0, py0, von0, hs0, vs0, fs0);
    mon(1, pt1, px1, py1, von1, hs1, vs1, fs1);
  end

  task automatic check_reset_state(input string nm);
    compare(0, nm, px0, py0, von0, hs0, vs0, reset_exp());
    compare(1, nm, px1, py1, von1, hs1, vs1, reset_exp());
    checks++;
    if (pt0 !== 1'b0 || pt1 !== 1'b0) begin
      errors++;
      $display("FAIL %s p_tick: got dut0=%b dut1=%b want 0", nm, pt0, pt1);
    end
  endtask

  task automatic check_first_tick(input string nm);
    repeat (3) @(negedge clk);
    checks++;
    if (pt0 !== 1'b0) begin
      errors++;
      $display("FAIL %s early p_tick dut0: got %b want 0", nm, pt0);
    end
    @(negedge clk);
    checks++;
    if (pt0 !== 1'b1 || px0 !== 10'd0 || py0 !== 10'd0 || von0 !== 1'b1) begin
      errors++;
      $display("FAIL %s first tick dut0: got pt=%b x=%0d y=%0d von=%b want pt=1 x=0 y=0 von=1",
               nm, pt0, px0, py0, von0);
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    check_first_tick("release");

    // Reset in the middle of a line.
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (px0 == 10'd300 && py0 == 10'd1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach x=300 y=1: got x=%0d y=%0d want x=300 y=1 within bound", px0, py0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("midline_reset");
    reset_n = 1'b1;
    check_first_tick("midline_release");

    // Randomly timed resets of random length.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(200, 9000)) @(negedge clk);
      reset_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check_reset_state("random_reset");
      reset_n = 1'b1;
    end

    repeat (8000) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
